// File: rtl/sofm_pkg.sv
// Shared types and constants for the SOFM training sequencer.
// Weight words are LANES x 8b; the write-back pipe depth matches the datapath latency.
package sofm_pkg;

  localparam int LANES    = 8;
  localparam int DATA_W   = LANES * 8;
  localparam int ADDR_W   = 16;
  localparam int WB_LAT   = 2;
  // Per-dimension sample shadow capacity; dimensions beyond this alias onto lower entries.
  localparam int XI_DEPTH = 16;
  localparam int XI_IW    = $clog2(XI_DEPTH);
  localparam int TMR_W    = $clog2(WB_LAT + 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SWEEP = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  // Index of the last 8-node group: ceil((len+1)^2 / 8) - 1, evaluated in 17 bits.
  function automatic logic [15:0] grp_last(input logic [7:0] len);
    logic [16:0] side;
    logic [16:0] nodes;
    logic [16:0] ng;
    side  = {9'd0, len} + 17'd1;
    nodes = side * side;
    ng    = (nodes + 17'd7) >> 3;
    return 16'(ng - 17'd1);
  endfunction

endpackage

// File: rtl/sofm_wb_pipe.sv
// Delay line carrying read-valid and read-address forward WB_LAT cycles,
// so the datapath's updated word lands back on the address it was read from.
module sofm_wb_pipe
  import sofm_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_vld,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_vld,
  output logic [ADDR_W-1:0] o_addr
);

  logic [WB_LAT-1:0] vld_q;
  logic [ADDR_W-1:0] addr_q [WB_LAT];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < WB_LAT; i++) addr_q[i] <= '0;
    end else begin
      vld_q[0]  <= i_vld;
      addr_q[0] <= i_addr;
      for (int i = 1; i < WB_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign o_vld  = vld_q[WB_LAT-1];
  assign o_addr = addr_q[WB_LAT-1];

endmodule

// File: rtl/sofm_seq_ctrl.sv
// SOFM training sequencer: iterations x inputs x 8-node groups x dimensions.
// Define SOFM_PERF_CNT_EN to build the busy-cycle and write-back counters.
//
//  state | meaning
//  IDLE  | waiting for i_start
//  SETUP | one cycle; rewind group/dimension walk for the next pass
//  SWEEP | one weight read per cycle over all groups and dimensions
//  FLUSH | WB_LAT+1 cycles; in-flight write-backs retire, then advance input/iteration
module sofm_seq_ctrl
  import sofm_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [7:0]        i_len,
  input  logic [15:0]       i_dim,
  input  logic [15:0]       i_ninput_last,
  input  logic [15:0]       i_nitr_last,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_state,
  output logic [15:0]       o_ndim,
  output logic [15:0]       o_ninput,
  output logic [15:0]       o_nitr,
  output logic              o_wram_re,
  output logic [ADDR_W-1:0] o_wram_raddr,
  input  logic [DATA_W-1:0] i_wram_rdata,
  output logic              o_wram_we,
  output logic [ADDR_W-1:0] o_wram_waddr,
  output logic [DATA_W-1:0] o_wram_wdata,
  output logic [ADDR_W-1:0] o_xram_addr,
  input  logic [7:0]        i_xram_rdata,
  output logic [7:0]        o_xi,
  output logic [7:0]        o_xi_1,
  input  logic              i_dp_update,
  input  logic [DATA_W-1:0] i_dp_data,
  output logic [31:0]       o_cyc_cnt,
  output logic [31:0]       o_upd_cnt
);

  state_e            state_q, state_d;
  logic [15:0]       dim_q, grp_q, ndim_q, ninput_q, nitr_q;
  logic [ADDR_W-1:0] base_q, xbase_q, dim_step;
  logic [TMR_W-1:0]  tmr_q;
  logic              rd_vld_q, cap_q, done_q;
  logic [7:0]        xi_cur_q  [XI_DEPTH];
  logic [7:0]        xi_prev_q [XI_DEPTH];

  logic last_dim, last_grp, last_in, last_itr, tmr_tc, first_pass;
  logic start_acc, next_pass, sweep;
  logic pipe_vld;
  logic [ADDR_W-1:0] pipe_addr;

  // Weight words pass straight from RAM to the datapath; only their timing matters here.
  logic unused_rdata;
  assign unused_rdata = ^i_wram_rdata;

  assign last_dim   = (dim_q == i_dim);
  assign last_grp   = (grp_q == grp_last(i_len));
  assign last_in    = (ninput_q == i_ninput_last);
  assign last_itr   = (nitr_q == i_nitr_last);
  assign tmr_tc     = (tmr_q == '0);
  assign first_pass = (ninput_q == 16'd0) && (nitr_q == 16'd0);
  assign dim_step   = ADDR_W'({1'b0, i_dim} + 17'd1);
  assign start_acc  = (state_q == ST_IDLE) && i_start;
  assign next_pass  = (state_q == ST_FLUSH) && tmr_tc && !(last_in && last_itr);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_start) state_d = ST_SETUP;
      ST_SETUP: state_d = ST_SWEEP;
      ST_SWEEP: if (last_dim && last_grp) state_d = ST_FLUSH;
      ST_FLUSH: if (tmr_tc) state_d = (last_in && last_itr) ? ST_IDLE : ST_SETUP;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sweep   = (state_q == ST_SWEEP);
    o_busy  = (state_q != ST_IDLE);
    o_state = state_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dim_q    <= '0;
      grp_q    <= '0;
      base_q   <= '0;
      xbase_q  <= '0;
      ninput_q <= '0;
      nitr_q   <= '0;
      ndim_q   <= '0;
      tmr_q    <= '0;
      rd_vld_q <= 1'b0;
      cap_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      rd_vld_q <= sweep;
      cap_q    <= sweep && (grp_q == 16'd0);
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            ninput_q <= '0;
            nitr_q   <= '0;
            xbase_q  <= '0;
          end
        end
        ST_SETUP: begin
          dim_q  <= '0;
          grp_q  <= '0;
          base_q <= '0;
        end
        ST_SWEEP: begin
          ndim_q <= dim_q;
          if (last_dim) begin
            dim_q <= '0;
            if (last_grp) begin
              grp_q  <= '0;
              base_q <= '0;
              tmr_q  <= TMR_W'(WB_LAT);
            end else begin
              grp_q  <= grp_q + 16'd1;
              base_q <= base_q + dim_step;
            end
          end else begin
            dim_q <= dim_q + 16'd1;
          end
        end
        ST_FLUSH: begin
          if (!tmr_tc) begin
            tmr_q <= tmr_q - TMR_W'(1);
          end else if (!last_in) begin
            ninput_q <= ninput_q + 16'd1;
            xbase_q  <= xbase_q + dim_step;
          end else if (!last_itr) begin
            ninput_q <= '0;
            nitr_q   <= nitr_q + 16'd1;
            xbase_q  <= '0;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Group 0 sees every dimension of the current input once; that pass fills the shadow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < XI_DEPTH; i++) begin
        xi_cur_q[i]  <= '0;
        xi_prev_q[i] <= '0;
      end
    end else begin
      if (cap_q) xi_cur_q[ndim_q[XI_IW-1:0]] <= i_xram_rdata;
      if (next_pass) xi_prev_q <= xi_cur_q;
    end
  end

  sofm_wb_pipe u_wb_pipe (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_vld   (o_wram_re),
    .i_addr  (o_wram_raddr),
    .o_vld   (pipe_vld),
    .o_addr  (pipe_addr)
  );

  assign o_wram_re    = sweep;
  assign o_wram_raddr = base_q + ADDR_W'(dim_q);
  assign o_xram_addr  = xbase_q + ADDR_W'(dim_q);
  assign o_ndim       = ndim_q;
  assign o_ninput     = ninput_q;
  assign o_nitr       = nitr_q;
  assign o_done       = done_q;
  assign o_xi         = rd_vld_q ? i_xram_rdata : 8'd0;
  assign o_xi_1       = (rd_vld_q && !first_pass) ? xi_prev_q[ndim_q[XI_IW-1:0]] : 8'd0;

  // The very first pass has no earlier winner, so nothing is written back.
  assign o_wram_we    = i_dp_update && pipe_vld && !first_pass;
  assign o_wram_waddr = pipe_addr;
  assign o_wram_wdata = o_wram_we ? i_dp_data : '0;

`ifdef SOFM_PERF_CNT_EN
  logic [31:0] cyc_q, upd_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cyc_q <= '0;
      upd_q <= '0;
    end else if (start_acc) begin
      cyc_q <= '0;
      upd_q <= '0;
    end else begin
      if (o_busy && !(&cyc_q))    cyc_q <= cyc_q + 32'd1;
      if (o_wram_we && !(&upd_q)) upd_q <= upd_q + 32'd1;
    end
  end

  assign o_cyc_cnt = cyc_q;
  assign o_upd_cnt = upd_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
  assign o_cyc_cnt = '0;
  assign o_upd_cnt = '0;
`endif

endmodule

// File: tb/tb_sofm_seq_ctrl.sv
// Directed bench for sofm_seq_ctrl: small RAM models plus a per-read reference of
// addresses, sample alignment and write-back timing, with run-level count checks.
module tb_sofm_seq_ctrl;
  import sofm_pkg::*;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_start = 1'b0;
  logic [7:0]        i_len = '0;
  logic [15:0]       i_dim = '0, i_ninput_last = '0, i_nitr_last = '0;
  logic              o_busy, o_done, o_wram_re, o_wram_we;
  logic [1:0]        o_state;
  logic [15:0]       o_ndim, o_ninput, o_nitr;
  logic [ADDR_W-1:0] o_wram_raddr, o_wram_waddr, o_xram_addr;
  logic [DATA_W-1:0] i_wram_rdata = '0, o_wram_wdata, i_dp_data = '0;
  logic [7:0]        i_xram_rdata = '0, o_xi, o_xi_1;
  logic              i_dp_update = 1'b0;
  logic [31:0]       o_cyc_cnt, o_upd_cnt;

  sofm_seq_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_len(i_len), .i_dim(i_dim),
    .i_ninput_last(i_ninput_last), .i_nitr_last(i_nitr_last), .o_busy(o_busy),
    .o_done(o_done), .o_state(o_state), .o_ndim(o_ndim), .o_ninput(o_ninput),
    .o_nitr(o_nitr), .o_wram_re(o_wram_re), .o_wram_raddr(o_wram_raddr),
    .i_wram_rdata(i_wram_rdata), .o_wram_we(o_wram_we), .o_wram_waddr(o_wram_waddr),
    .o_wram_wdata(o_wram_wdata), .o_xram_addr(o_xram_addr), .i_xram_rdata(i_xram_rdata),
    .o_xi(o_xi), .o_xi_1(o_xi_1), .i_dp_update(i_dp_update), .i_dp_data(i_dp_data),
    .o_cyc_cnt(o_cyc_cnt), .o_upd_cnt(o_upd_cnt)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xf(input int a);
    return 8'(a) ^ 8'h3C;
  endfunction

  // RAM models: one-cycle registered read.
  always @(posedge i_clk) begin
    i_xram_rdata <= xf(int'(o_xram_addr));
    i_wram_rdata <= {4{o_wram_raddr}};
  end

  int mon_en = 0, rpp = 1, dims = 1, nin_n = 1;
  int cnt_re = 0, cnt_we = 0, cnt_done = 0, cnt_busy = 0, cnt_flush = 0;
  int re_d1 = 0, re_d2 = 0, idx_d1 = 0, idx_d2 = 0;
  int mp, mj, md, mn, mpn, exp_we;

  // Reference for each read index i: pass = i/rpp, raddr = i%rpp, dim = raddr%dims.
  always @(negedge i_clk) begin
    if (o_wram_we) cnt_we++;
    if (o_done) cnt_done++;
    if (o_busy) cnt_busy++;
    if (o_state == 2'd3) cnt_flush++;
    if (mon_en != 0) begin
      if (re_d1 != 0) begin
        mp = idx_d1 / rpp; mj = idx_d1 % rpp; md = mj % dims; mn = mp % nin_n;
        mpn = (mn == 0) ? nin_n - 1 : mn - 1;
        chk("ndim", 64'(o_ndim), 64'(md));
        chk("xi", 64'(o_xi), 64'(xf(mn * dims + md)));
        chk("xi_1", 64'(o_xi_1), (mp == 0) ? 64'd0 : 64'(xf(mpn * dims + md)));
      end
      exp_we = (re_d2 != 0 && (idx_d2 / rpp) != 0 && i_dp_update) ? 1 : 0;
      chk("we", 64'(o_wram_we), 64'(exp_we));
      if (exp_we != 0) begin
        chk("waddr", 64'(o_wram_waddr), 64'(idx_d2 % rpp));
        chk("wdata", 64'(o_wram_wdata), 64'(i_dp_data));
      end
      if (o_wram_re) begin
        mp = cnt_re / rpp; mj = cnt_re % rpp; md = mj % dims; mn = mp % nin_n;
        chk("raddr", 64'(o_wram_raddr), 64'(mj));
        chk("xaddr", 64'(o_xram_addr), 64'(mn * dims + md));
      end
    end
    re_d2 = re_d1; idx_d2 = idx_d1;
    re_d1 = o_wram_re ? 1 : 0; idx_d1 = cnt_re;
    if (o_wram_re) cnt_re++;
  end

  task automatic clear_mon(input int en);
    @(posedge i_clk); #1;
    cnt_re = 0; cnt_we = 0; cnt_done = 0; cnt_busy = 0; cnt_flush = 0;
    re_d1 = 0; re_d2 = 0; idx_d1 = 0; idx_d2 = 0;
    mon_en = en;
  endtask

  task automatic set_cfg(input int len, input int dim, input int nl, input int il);
    int ng;
    i_len = 8'(len); i_dim = 16'(dim); i_ninput_last = 16'(nl); i_nitr_last = 16'(il);
    ng = ((len + 1) * (len + 1) + 7) / 8;
    dims = dim + 1; rpp = ng * dims; nin_n = nl + 1;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_state"}, 64'(o_state), 64'd0);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_done"}, 64'(o_done), 64'd0);
    chk({tag, "_re"}, 64'(o_wram_re), 64'd0);
    chk({tag, "_we"}, 64'(o_wram_we), 64'd0);
    chk({tag, "_raddr"}, 64'(o_wram_raddr), 64'd0);
    chk({tag, "_waddr"}, 64'(o_wram_waddr), 64'd0);
    chk({tag, "_wdata"}, 64'(o_wram_wdata), 64'd0);
    chk({tag, "_xaddr"}, 64'(o_xram_addr), 64'd0);
    chk({tag, "_ninput"}, 64'(o_ninput), 64'd0);
    chk({tag, "_nitr"}, 64'(o_nitr), 64'd0);
    chk({tag, "_ndim"}, 64'(o_ndim), 64'd0);
    chk({tag, "_xi"}, 64'(o_xi), 64'd0);
    chk({tag, "_xi_1"}, 64'(o_xi_1), 64'd0);
    chk({tag, "_cyc"}, 64'(o_cyc_cnt), 64'd0);
    chk({tag, "_upd"}, 64'(o_upd_cnt), 64'd0);
  endtask

  task automatic run(input string tag, input int len, input int dim, input int nl,
                     input int il, input int glitch);
    int passes, seen;
    set_cfg(len, dim, nl, il);
    i_dp_update = 1'b1;
    i_dp_data   = 64'hA5C3_0123_4567_89AB ^ 64'(len * 1000 + dim);
    clear_mon(1);
    passes = (nl + 1) * (il + 1);
    seen = 0;
    @(negedge i_clk); i_start = 1'b1;
    for (int c = 0; c < 4000 && seen == 0; c++) begin
      @(negedge i_clk);
      i_start = (glitch != 0 && c == 10);
      if (o_done) seen = 1;
    end
    i_start = 1'b0;
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    repeat (2) @(negedge i_clk);
    chk({tag, "_reads"}, 64'(cnt_re), 64'(passes * rpp));
    chk({tag, "_writes"}, 64'(cnt_we), 64'((passes - 1) * rpp));
    chk({tag, "_done_cnt"}, 64'(cnt_done), 64'd1);
    chk({tag, "_busy_cyc"}, 64'(cnt_busy), 64'(passes * (rpp + WB_LAT + 2)));
    chk({tag, "_flush_cyc"}, 64'(cnt_flush), 64'(passes * (WB_LAT + 1)));
    chk({tag, "_idle"}, 64'(o_busy), 64'd0);
`ifdef SOFM_PERF_CNT_EN
    chk({tag, "_upd_cnt"}, 64'(o_upd_cnt), 64'((passes - 1) * rpp));
    chk({tag, "_cyc_cnt"}, 64'(o_cyc_cnt), 64'(passes * (rpp + WB_LAT + 2)));
`else
    chk({tag, "_upd_cnt"}, 64'(o_upd_cnt), 64'd0);
    chk({tag, "_cyc_cnt"}, 64'(o_cyc_cnt), 64'd0);
`endif
  endtask

  initial begin
    int seen;
    // Reset state
    repeat (3) @(negedge i_clk);
    check_idle_zero("rst");
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    check_idle_zero("post_rst");

    // 1: NG=2, two dims, single pass: reads 0..3, no writes
    run("t1", 3, 1, 0, 0, 0);
    // 2: NG=8, three dims, 2 inputs x 2 iterations
    run("t2", 7, 2, 1, 1, 0);
    // 3: smallest map, one read per pass
    run("t3", 0, 0, 1, 1, 0);
    // 4: start pulse during SWEEP must be ignored
    run("t4", 7, 2, 1, 1, 1);

    // 5: reset during SWEEP with writes in flight
    set_cfg(7, 2, 1, 1);
    i_dp_update = 1'b1;
    clear_mon(0);
    @(negedge i_clk); i_start = 1'b1;
    @(negedge i_clk); i_start = 1'b0;
    seen = 0;
    for (int c = 0; c < 500 && seen == 0; c++) begin
      @(negedge i_clk);
      if (cnt_we > 3 && o_state == 2'd2) seen = 1;
    end
    chk("t5_mid_sweep", 64'(seen), 64'd1);
    i_rst_n = 1'b0;
    #1;
    check_idle_zero("t5_rst");
    clear_mon(0);
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("t5_no_we", 64'(cnt_we), 64'd0);
    chk("t5_no_done", 64'(cnt_done), 64'd0);
    check_idle_zero("t5_after");
    run("t5_restart", 3, 1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
